// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state encoding and default
// starvation limit.
package riscv_mem_arbiter_pkg;

    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IFU = 2'd1,
        BUSY_LSU = 2'd2
    } mem_arb_state_t;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single-outstanding memory port. LSU has
// priority, bounded by a starvation counter that forces an IFU slot.
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clk_i,
    input  logic        reset_ni,

    input  logic        ifu_req_i,
    input  logic [29:0] ifu_addr_i,
    input  logic        ifu_flush_i,
    output logic        ifu_gnt_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,

    input  logic        lsu_req_i,
    input  logic [29:0] lsu_addr_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,

    output logic        mem_req_o,
    output logic [29:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    mem_arb_state_t r_state, w_next;
    logic [CW-1:0]  r_starve;
    logic           r_flush_pend;

    logic w_idle, w_sel_lsu, w_sel_ifu, w_ifu_hs, w_lsu_hs, w_ifu_resp;

    // Gating with reset_ni keeps every strobe low while reset is held.
    assign w_idle     = (r_state == IDLE) & reset_ni;
    assign w_sel_lsu  = w_idle & lsu_req_i & ~((r_starve == LIM) & ifu_req_i);
    assign w_sel_ifu  = w_idle & ifu_req_i & ~w_sel_lsu;
    assign w_ifu_hs   = w_sel_ifu & mem_gnt_i;
    assign w_lsu_hs   = w_sel_lsu & mem_gnt_i;
    assign w_ifu_resp = reset_ni & (r_state == BUSY_IFU) & mem_rvalid_i;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) r_state <= IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_lsu_hs)      w_next = BUSY_LSU;
                else if (w_ifu_hs) w_next = BUSY_IFU;
            end
            BUSY_IFU, BUSY_LSU: begin
                if (mem_rvalid_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o    = w_sel_ifu | w_sel_lsu;
        mem_addr_o   = '0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;
        ifu_gnt_o    = w_ifu_hs;
        lsu_gnt_o    = w_lsu_hs;
        ifu_rvalid_o = 1'b0;
        ifu_rdata_o  = '0;
        lsu_rvalid_o = 1'b0;
        lsu_rdata_o  = '0;
        if (w_sel_lsu) begin
            mem_addr_o  = lsu_addr_i;
            mem_we_o    = lsu_we_i;
            mem_be_o    = lsu_be_i;
            mem_wdata_o = lsu_wdata_i;
        end else if (w_sel_ifu) begin
            mem_addr_o = ifu_addr_i;
            mem_be_o   = 4'hF;
        end
        // A flush on the response cycle itself also discards the fetch.
        if (w_ifu_resp && !r_flush_pend && !ifu_flush_i) begin
            ifu_rvalid_o = 1'b1;
            ifu_rdata_o  = mem_rdata_i;
        end
        if (reset_ni && r_state == BUSY_LSU && mem_rvalid_i) begin
            lsu_rvalid_o = 1'b1;
            lsu_rdata_o  = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_starve     <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_ifu_hs)
                r_starve <= '0;
            else if (w_lsu_hs)
                r_starve <= !ifu_req_i ? '0 : (r_starve == LIM) ? LIM : r_starve + CW'(1);

            if (w_ifu_resp)
                r_flush_pend <= 1'b0;
            else if (ifu_flush_i && ((r_state == BUSY_IFU) || w_ifu_hs))
                r_flush_pend <= 1'b1;
        end
    end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, giving the max consecutive LSU grants while the IFU waits.
REQ-002 SHALL have clk_i  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have reset_ni  in  1  reset: one clock, synchronous, active-low.
REQ-004 SHALL have ifu_req_i  in  1 / ifu_addr_i  in  30  IFU word-address fetch request.
REQ-005 SHALL have ifu_flush_i  in  1  branch clear; drops the IFU response in flight.
REQ-006 SHALL have ifu_gnt_o  out  1 / ifu_rvalid_o  out  1 / ifu_rdata_o  out  32  IFU grant and response.
REQ-007 SHALL have the LSU request inputs, each an input:
- lsu_req_i, width 1.
- lsu_addr_i, width 30.
- lsu_we_i, width 1.
- lsu_be_i, width 4.
- lsu_wdata_i, width 32.
REQ-008 SHALL have lsu_gnt_o  out  1 / lsu_rvalid_o  out  1 / lsu_rdata_o  out  32  LSU grant and response.
REQ-009 SHALL have the memory request outputs, each an output:
- mem_req_o, width 1.
- mem_addr_o, width 30.
- mem_we_o, width 1.
- mem_be_o, width 4.
- mem_wdata_o, width 32.
REQ-010 SHALL have mem_gnt_i  in  1 / mem_rvalid_i  in  1 / mem_rdata_i  in  32  memory grant and response.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_IFU, BUSY_LSU; at most one transaction is outstanding.
REQ-012 In IDLE, SHALL select the LSU if lsu_req_i, unless starve_cnt==STARVE_LIMIT and ifu_req_i, in which case it SHALL select the IFU.
REQ-013 In IDLE, SHALL select the IFU if only ifu_req_i is high.
REQ-014 In IDLE, SHALL drive mem_req_o and the mem_* fields combinationally from the selected requester.
REQ-015 An IFU request SHALL drive mem_we_o=0 and mem_be_o=4'hF.
REQ-016 SHALL assert <sel>_gnt_o = mem_gnt_i & mem_req_o for the selected requester only, with zero extra latency.
REQ-017 On a grant handshake, SHALL move to BUSY_<sel> on the next edge.
REQ-018 In BUSY_*, SHALL hold mem_req_o=0 and both gnt outputs at 0.
REQ-019 In BUSY_x with mem_rvalid_i, SHALL assert x_rvalid_o=1 and x_rdata_o=mem_rdata_i in that same cycle, then return to IDLE.
REQ-020 The earliest next mem_req_o SHALL be the cycle after a response (2-cycle minimum per transaction).
REQ-021 Writes SHALL also complete on mem_rvalid_i; lsu_rvalid_o pulses and lsu_rdata_o is don't-care.
REQ-022 mem_rvalid_i in IDLE SHALL be ignored; no rvalid output pulses.
REQ-023 The non-owner rvalid output SHALL be 0 in every cycle.
REQ-024 Flush handling:
- ifu_flush_i in BUSY_IFU, or in the IDLE cycle of an IFU grant, SHALL set a flush_pending flag.
- The matching response SHALL still return the FSM to IDLE, but ifu_rvalid_o SHALL stay 0.
- flush_pending SHALL clear on that response.
REQ-025 ifu_flush_i SHALL NOT affect LSU transactions.
REQ-026 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL count up as follows:
- +1 on an LSU grant while ifu_req_i=1.
- It saturates at STARVE_LIMIT.
REQ-027 starve_cnt SHALL reset to 0 as follows:
- To 0 on any IFU grant.
- To 0 on an LSU grant while ifu_req_i=0.
REQ-028 Requests withdrawn before grant SHALL be legal; selection is re-evaluated every IDLE cycle.

Reset
REQ-029 With reset_ni=0 at a posedge, the block SHALL reset state, counter and flag:
- State to IDLE.
- starve_cnt to 0.
- flush_pending to 0.
REQ-030 While reset_ni=0, all *_gnt_o, *_rvalid_o and mem_req_o SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction; a late mem_rvalid_i after reset SHALL be ignored per REQ-022.
REQ-032 Data outputs (rdata, addr, wdata, be, we) SHALL be 0 when not selected or valid.

Structure
REQ-033 The state typedef mem_arb_state_t and the default STARVE_LIMIT SHALL live in the shared riscv package.
REQ-034 SHALL be a single module with no sub-module; the FSM and counter are inline.

Verification
REQ-035 Scenario: IFU only, addr 30'h100, mem_gnt_i=1, rvalid next cycle with 32'hDEADBEEF -> ifu_gnt_o cycle 0, then ifu_rvalid_o and ifu_rdata_o=DEADBEEF cycle 1.
REQ-036 Scenario: IFU and LSU both request in the same cycle with starve_cnt=0 -> LSU granted first, IFU granted in the next IDLE cycle after the LSU response.
REQ-037 Scenario: both request continuously with STARVE_LIMIT=4 -> grant order L,L,L,L,I,L,L,L,L,I,...
REQ-038 Scenario: IFU granted, ifu_flush_i pulses in BUSY_IFU, rvalid 32'h12345678 -> ifu_rvalid_o stays 0 and the FSM returns to IDLE.
REQ-039 Scenario: LSU store be=4'b0011, wdata 32'hAABBCCDD, mem_gnt_i held 0 for 3 cycles -> mem_* fields stable for 3 cycles, lsu_gnt_o only on the cycle mem_gnt_i=1.
REQ-040 Scenario: reset_ni=0 in BUSY_LSU, then mem_rvalid_i=1 after reset release -> no lsu_rvalid_o and no ifu_rvalid_o, state IDLE.
